// File: rtl/paula_floppy_dma_ctrl.sv
// Paula floppy DMA sequencer: DSKLEN double-write arming, read/write word flow
// between disk shifter, word FIFO and Agnus DMA slots, DSKBLK generation.
module paula_floppy_dma_ctrl #(
  parameter int unsigned LEN_W = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk7_en,
  input  logic             dsklen_wr,
  input  logic [15:0]      data_in,
  input  logic             wordsync_en,
  input  logic             sync_match,
  input  logic             disk_word_strobe,
  input  logic             disk_word_req,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic             dma_ack,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic             fifo_reset,
  output logic             dma_req,
  output logic             dma_dir,
  output logic             busy,
  output logic             blkdone,
  output logic             overrun,
  output logic             underrun
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_SYNC = 3'd1,
    S_READ      = 3'd2,
    S_WRITE     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               armed;
  logic [LEN_W-1:0]   in_cnt;
  logic [LEN_W-1:0]   out_cnt;

  logic               wr_dmaen;
  logic [LEN_W-1:0]   len_in;
  logic               abort;
  logic               arm;
  logic               start;
  logic               in_nz;
  logic               out_nz;
  logic               out_last;

  assign wr_dmaen = data_in[15];
  assign len_in   = data_in[LEN_W-1:0];
  assign in_nz    = (in_cnt != '0);
  assign out_nz   = (out_cnt != '0);
  assign out_last = (out_cnt == LEN_W'(1));

  // DSKLEN decode: clear, first (arming) write, second (starting) write
  assign abort = clk7_en & dsklen_wr & ~wr_dmaen;
  assign arm   = clk7_en & dsklen_wr & wr_dmaen & (state_q == S_IDLE) & ~armed;
  assign start = clk7_en & dsklen_wr & wr_dmaen & (state_q == S_IDLE) & armed;

  // State register; busy is the registered decode of the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
    end else if (clk7_en) begin
      state_q <= state_d;
      busy    <= (state_d == S_WAIT_SYNC) || (state_d == S_READ) || (state_d == S_WRITE);
    end
  end

  // Next state and combinational FIFO/DMA strobes
  always_comb begin
    state_d = state_q;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    dma_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_in == '0)     state_d = S_DONE;
          else if (data_in[14]) state_d = S_WRITE;
          else if (wordsync_en) state_d = S_WAIT_SYNC;
          else                  state_d = S_READ;
        end
      end
      S_WAIT_SYNC: begin
        if (clk7_en && sync_match) state_d = S_READ;
      end
      S_READ: begin
        fifo_wr = clk7_en & disk_word_strobe & ~fifo_full & in_nz;
        dma_req = clk7_en & ~fifo_empty & out_nz;
        fifo_rd = dma_req & dma_ack;
        if (fifo_rd && out_last) state_d = S_DONE;
      end
      S_WRITE: begin
        dma_req = clk7_en & ~fifo_full & in_nz;
        fifo_wr = dma_req & dma_ack;
        fifo_rd = clk7_en & disk_word_req & ~fifo_empty & out_nz;
        if (fifo_rd && out_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (clk7_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A clearing DSKLEN write wins over everything and suppresses strobes
    if (abort) begin
      state_d = S_IDLE;
      fifo_wr = 1'b0;
      fifo_rd = 1'b0;
      dma_req = 1'b0;
    end
  end

  // Arm flag and latched transfer direction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed   <= 1'b0;
      dma_dir <= 1'b0;
    end else if (clk7_en) begin
      if (abort)                    armed <= 1'b0;
      else if (arm)                 armed <= 1'b1;
      else if (state_q == S_DONE)   armed <= 1'b0;
      if (arm || start)             dma_dir <= data_in[14];
    end
  end

  // Word counters: load on start, decrement per FIFO transfer, never wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (clk7_en) begin
      if (start) begin
        in_cnt  <= len_in;
        out_cnt <= len_in;
      end else begin
        if (fifo_wr && in_nz)  in_cnt  <= in_cnt - LEN_W'(1);
        if (fifo_rd && out_nz) out_cnt <= out_cnt - LEN_W'(1);
      end
    end
  end

  // One-enabled-cycle pulses: FIFO clear on start/abort, DSKBLK on entry to DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_reset <= 1'b0;
      blkdone    <= 1'b0;
    end else if (clk7_en) begin
      fifo_reset <= abort | start;
      blkdone    <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  // Sticky error flags, cleared by a DSKLEN write with DMAEN=0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (clk7_en) begin
      if (abort) begin
        overrun  <= 1'b0;
        underrun <= 1'b0;
      end else begin
        if ((state_q == S_READ) && disk_word_strobe && fifo_full && in_nz)
          overrun <= 1'b1;
        if ((state_q == S_WRITE) && disk_word_req && fifo_empty && out_nz)
          underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paula_floppy_dma_ctrl.sv
// Directed self-checking bench for paula_floppy_dma_ctrl.
module tb_paula_floppy_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk7_en;
  logic        dsklen_wr;
  logic [15:0] data_in;
  logic        wordsync_en;
  logic        sync_match;
  logic        disk_word_strobe;
  logic        disk_word_req;
  logic        fifo_empty;
  logic        fifo_full;
  logic        dma_ack;
  logic        fifo_wr, fifo_rd, fifo_reset, dma_req, dma_dir;
  logic        busy, blkdone, overrun, underrun;

  int checks = 0;
  int errors = 0;

  // Bench-side FIFO occupancy model and event counters
  int fcnt = 0;
  logic force_full = 1'b0;
  int n_wr, n_rd, n_blk, n_cyc, last_rd_at, blk_at;

  paula_floppy_dma_ctrl #(.LEN_W(14)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .dsklen_wr(dsklen_wr),
    .data_in(data_in), .wordsync_en(wordsync_en), .sync_match(sync_match),
    .disk_word_strobe(disk_word_strobe), .disk_word_req(disk_word_req),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .dma_ack(dma_ack),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_reset(fifo_reset),
    .dma_req(dma_req), .dma_dir(dma_dir), .busy(busy), .blkdone(blkdone),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flags();
    fifo_empty = (fcnt == 0);
    fifo_full  = force_full || (fcnt >= 4);
  endtask

  task automatic clr_counts();
    n_wr = 0; n_rd = 0; n_blk = 0; n_cyc = 0; last_rd_at = -1; blk_at = -1;
  endtask

  // One clock cycle: settle, sample strobes, update FIFO model, advance to edge+1
  task automatic cyc();
    flags();
    #1;
    if (fifo_wr) n_wr++;
    if (fifo_rd) begin n_rd++; last_rd_at = n_cyc; end
    if (blkdone) begin n_blk++; blk_at = n_cyc; end
    if (fifo_reset) fcnt = 0;
    fcnt = fcnt + int'(fifo_wr) - int'(fifo_rd);
    n_cyc++;
    @(posedge clk); #1;
  endtask

  task automatic dsklen(input logic [15:0] v);
    dsklen_wr = 1'b1; data_in = v;
    cyc();
    dsklen_wr = 1'b0; data_in = 16'h0;
  endtask

  initial begin
    reset_n = 1'b0; clk7_en = 1'b1; dsklen_wr = 1'b0; data_in = 16'h0;
    wordsync_en = 1'b0; sync_match = 1'b0; disk_word_strobe = 1'b0;
    disk_word_req = 1'b0; dma_ack = 1'b0;
    flags();
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {fifo_wr, fifo_rd, fifo_reset, dma_req, dma_dir, blkdone, overrun, underrun}, 0);
    chk("rst_armed", 32'(dut.armed), 0);
    #9 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single arming write does not start
    dsklen(16'h8004);
    chk("arm_armed", 32'(dut.armed), 1);
    chk("arm_noreset", 32'(fifo_reset), 0);
    for (int i = 0; i < 100; i++) cyc();
    chk("arm_busy", 32'(busy), 0);
    chk("arm_dmareq", 32'(dma_req), 0);
    chk("arm_still", 32'(dut.armed), 1);
    dsklen(16'h0000);
    chk("clr_armed", 32'(dut.armed), 0);
    chk("clr_freset", 32'(fifo_reset), 1);
    cyc();
    chk("clr_freset_1cyc", 32'(fifo_reset), 0);
    dsklen(16'h8004);
    cyc(); cyc();
    chk("rearm_nostart", 32'(busy), 0);
    dsklen(16'h0000);

    // Read, no wordsync, LEN=3
    clr_counts();
    wordsync_en = 1'b0; dma_ack = 1'b1;
    dsklen(16'h8003);
    dsklen(16'h8003);
    chk("rd_busy", 32'(busy), 1);
    chk("rd_freset", 32'(fifo_reset), 1);
    chk("rd_dir", 32'(dma_dir), 0);
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      disk_word_strobe = (i % 2 == 0) && (i < 6);
      cyc();
    end
    disk_word_strobe = 1'b0;
    chk("rd_nwr", 32'(n_wr), 3);
    chk("rd_nrd", 32'(n_rd), 3);
    chk("rd_nblk", 32'(n_blk), 1);
    chk("rd_idle_busy", 32'(busy), 0);
    chk("rd_idle_armed", 32'(dut.armed), 0);

    // Read with wordsync, LEN=2: pre-sync strobes dropped
    wordsync_en = 1'b1;
    dsklen(16'h8002);
    dsklen(16'h8002);
    chk("ws_busy", 32'(busy), 1);
    clr_counts();
    for (int i = 0; i < 16; i++) begin
      disk_word_strobe = (i == 0) || (i == 1) || (i == 4) || (i == 6);
      sync_match = (i == 2);
      cyc();
    end
    disk_word_strobe = 1'b0; sync_match = 1'b0; wordsync_en = 1'b0;
    chk("ws_nwr", 32'(n_wr), 2);
    chk("ws_nrd", 32'(n_rd), 2);
    chk("ws_nblk", 32'(n_blk), 1);
    chk("ws_blk_after_rd", 32'(blk_at), 32'(last_rd_at + 1));

    // Write mode, LEN=2, with an early underrun
    dma_ack = 1'b0;
    dsklen(16'hC002);
    dsklen(16'hC002);
    chk("wr_dir", 32'(dma_dir), 1);
    chk("wr_busy", 32'(busy), 1);
    clr_counts();
    disk_word_req = 1'b1; flags(); #1;
    chk("wr_dmareq", 32'(dma_req), 1);
    chk("wr_underrun_rd", 32'(fifo_rd), 0);
    cyc();
    disk_word_req = 1'b0;
    chk("wr_underrun", 32'(underrun), 1);
    dma_ack = 1'b1;
    cyc(); cyc();
    dma_ack = 1'b0; flags(); #1;
    chk("wr_nwr", 32'(n_wr), 2);
    chk("wr_dmareq_done", 32'(dma_req), 0);
    for (int i = 0; i < 8; i++) begin
      disk_word_req = (i == 1) || (i == 3);
      cyc();
    end
    disk_word_req = 1'b0;
    chk("wr_nrd", 32'(n_rd), 2);
    chk("wr_nblk", 32'(n_blk), 1);
    chk("wr_underrun_sticky", 32'(underrun), 1);
    chk("wr_dir_hold", 32'(dma_dir), 1);
    dsklen(16'h0000);
    chk("wr_underrun_clr", 32'(underrun), 0);

    // LEN=0 goes straight to DONE
    clr_counts();
    dsklen(16'h8000);
    dsklen(16'h8000);
    chk("len0_blk", 32'(blkdone), 1);
    chk("len0_busy", 32'(busy), 0);
    cyc();
    chk("len0_blk_1cyc", 32'(blkdone), 0);
    chk("len0_armed", 32'(dut.armed), 0);

    // Overrun, clock-enable gating, then abort mid-transfer
    dsklen(16'h8005);
    dsklen(16'h8005);
    clr_counts();
    clk7_en = 1'b0; disk_word_strobe = 1'b1; flags(); #1;
    chk("gate_wr", 32'(fifo_wr), 0);
    cyc();
    clk7_en = 1'b1; force_full = 1'b1; flags(); #1;
    chk("ovr_wr", 32'(fifo_wr), 0);
    cyc();
    disk_word_strobe = 1'b0; force_full = 1'b0;
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_busy", 32'(busy), 1);
    dsklen(16'h0000);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_freset", 32'(fifo_reset), 1);
    chk("abort_ovr", 32'(overrun), 0);
    for (int i = 0; i < 10; i++) cyc();
    chk("abort_noblk", 32'(n_blk), 0);

    // Async reset in the middle of a write transfer
    dsklen(16'hC004);
    dsklen(16'hC004);
    dma_ack = 1'b1;
    cyc();
    dma_ack = 1'b0; flags(); #1;
    chk("ar_pre_busy", 32'(busy), 1);
    chk("ar_pre_req", 32'(dma_req), 1);
    reset_n = 1'b0;
    #1;
    chk("ar_outs", {busy, fifo_wr, fifo_rd, fifo_reset, dma_req, dma_dir, blkdone, overrun, underrun}, 0);
    #1 reset_n = 1'b1;
    fcnt = 0;
    @(posedge clk); #1;
    cyc();
    chk("ar_busy", 32'(busy), 0);
    chk("ar_armed", 32'(dut.armed), 0);
    dsklen(16'h8004);
    cyc();
    chk("ar_single_nostart", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
